// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, opcode values and a clog2 helper.
package alu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/addsub_slice.sv
// K-bit combinational ripple adder built from full-adder cells; also exposes
// the carry into its MSB so the top can derive signed overflow on the last slice.
module addsub_slice #(
   parameter int K = 2
) (
   input  logic [K-1:0] a,
   input  logic [K-1:0] b,
   input  logic         cin,
   output logic [K-1:0] sum,
   output logic         cout,
   output logic         cmsb
);

   logic [K:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < K; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[K];
   assign cmsb = c[K-1];

endmodule

// File: rtl/seq_adder_subtractor.sv
// Multi-cycle N-bit add/subtract processing one K-bit slice per clock through a
// single shared slice adder, with start/busy/done handshake and carry/overflow/zero flags.
module seq_adder_subtractor
   import alu_pkg::*;
#(
   parameter int N = 8,
   parameter int K = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sub,
   input  logic [N-1:0] X,
   input  logic [N-1:0] Y,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] Result,
   output logic         carryOut,
   output logic         overflow,
   output logic         zero
);

   localparam int SLICES = N / K;
   localparam int CW     = (clog2(SLICES) < 1) ? 1 : clog2(SLICES);
   localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

   if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad_params
      $error("seq_adder_subtractor: illegal N/K combination");
   end

   state_t        state, nxt;
   logic [CW-1:0] cnt;
   logic [N-1:0]  op_a, op_b, acc, acc_nxt;
   logic          cy;
   logic [K-1:0]  a_sl, b_sl, s_sl;
   logic          c_out, c_msb;
   logic          accept, last;

   assign accept = start && (state != ST_BUSY);
   assign last   = (cnt == LAST);
   assign a_sl   = K'(op_a >> (int'(cnt) * K));
   assign b_sl   = K'(op_b >> (int'(cnt) * K));

   addsub_slice #(.K(K)) u_slice (
      .a    (a_sl),
      .b    (b_sl),
      .cin  (cy),
      .sum  (s_sl),
      .cout (c_out),
      .cmsb (c_msb)
   );

   // Shadow result with the current slice merged in, so the final slice can
   // be published on the same edge that enters DONE.
   always_comb begin
      acc_nxt = acc;
      acc_nxt[int'(cnt) * K +: K] = s_sl;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE: if (start) nxt = ST_BUSY;
         ST_BUSY: if (last)  nxt = ST_DONE;
         ST_DONE: nxt = start ? ST_BUSY : ST_IDLE;
         default: nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ST_BUSY);
      done = (state == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         op_a     <= '0;
         op_b     <= '0;
         cy       <= 1'b0;
         acc      <= '0;
         Result   <= '0;
         carryOut <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else if (accept) begin
         op_a <= X;
         op_b <= Y ^ {N{sub}};
         cy   <= (sub == OP_SUB);
         cnt  <= '0;
      end else if (state == ST_BUSY) begin
         acc <= acc_nxt;
         cy  <= c_out;
         if (last) begin
            Result   <= acc_nxt;
            carryOut <= c_out;
            overflow <= c_out ^ c_msb;
            zero     <= ~|acc_nxt;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule
